// File: rtl/seq_divider32_if.sv
// Start/valid handshake bundle for the 32/16 sequential divider.
// The master drives the operands and start; the slave returns status and results.
interface seq_divider32_if;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider32.sv
// Restoring divider: 32-bit unsigned dividend by 16-bit unsigned divisor.
// Produces one quotient bit per clock, so a result is ready 33 cycles after start.
module seq_divider32 (
  input logic             clk,
  input logic             rst_n,
  seq_divider32_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [16:0] prem;
  logic [31:0] work;
  logic [15:0] dvsr;
  logic [5:0]  cnt;
  logic        valid_r;
  logic [31:0] quot_r;
  logic [15:0] rem_r;
  logic        dbz_r;
  logic [48:0] step;

  // One restoring iteration: shift {prem, work} left, trial-subtract the divisor,
  // and feed the new quotient bit into the vacated LSB of work.
  function automatic logic [48:0] div_step(input logic [16:0] p,
                                           input logic [31:0] w,
                                           input logic [15:0] d);
    logic        [16:0] sh;
    logic signed [17:0] diff;
    sh   = {p[15:0], w[31]};
    diff = signed'({1'b0, sh}) - signed'({2'b00, d});
    if (diff >= 0)
      return {diff[16:0], w[30:0], 1'b1};
    else
      return {sh, w[30:0], 1'b0};
  endfunction

  assign step = div_step(prem, work, dvsr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      prem    <= '0;
      work    <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor != 16'd0) begin
              dvsr  <= bus.divisor;
              work  <= bus.dividend;
              prem  <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              quot_r  <= 32'hFFFF_FFFF;
              rem_r   <= bus.dividend[15:0];
              dbz_r   <= 1'b1;
              valid_r <= 1'b1;
              state   <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          prem <= step[48:32];
          work <= step[31:0];
          cnt  <= cnt + 6'd1;
          // The 32nd iteration lands directly in the result registers.
          if (cnt == 6'd31) begin
            quot_r  <= step[31:0];
            rem_r   <= step[47:32];
            dbz_r   <= 1'b0;
            valid_r <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready       = (state == IDLE) || (state == DONE);
  assign bus.busy        = (state == CALC);
  assign bus.valid       = valid_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: latency, results, handshake, divide-by-zero and reset.
module tb_seq_divider32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  seq_divider32_if bus();

  seq_divider32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for valid; lat counts edges from the accepting edge.
  task automatic wait_valid(inout int lat);
    while (bus.valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, output int lat);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    tick();
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    lat = 1;
    wait_valid(lat);
  endtask

  task automatic expect_res(input string tag, input int lat, input int exp_lat,
                            input logic [31:0] q, input logic [15:0] r, input logic z);
    chk({tag, ".lat"},   32'(lat),             32'(exp_lat));
    chk({tag, ".valid"}, 32'(bus.valid),       32'd1);
    chk({tag, ".quot"},  bus.quotient,         q);
    chk({tag, ".rem"},   32'(bus.remainder),   32'(r));
    chk({tag, ".dbz"},   32'(bus.div_by_zero), 32'(z));
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] dd;
    logic [15:0] dv;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    chk("reset.ready", 32'(bus.ready),       32'd1);
    chk("reset.busy",  32'(bus.busy),        32'd0);
    chk("reset.valid", 32'(bus.valid),       32'd0);
    chk("reset.quot",  bus.quotient,         32'd0);
    chk("reset.rem",   32'(bus.remainder),   32'd0);
    chk("reset.dbz",   32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(32'd1000, 16'd7, lat);
    expect_res("basic", lat, 33, 32'd142, 16'd6, 1'b0);
    tick();
    chk("basic.valid_drop", 32'(bus.valid), 32'd0);
    chk("basic.ready_idle", 32'(bus.ready), 32'd1);
    chk("basic.hold_quot",  bus.quotient,   32'd142);

    run_op(32'hFFFE_0001, 16'hFFFF, lat);
    expect_res("inv_ffff", lat, 33, 32'h0000_FFFF, 16'h0000, 1'b0);
    // start in the valid cycle is accepted back-to-back
    run_op(32'hFFFF_FFFF, 16'd1, lat);
    expect_res("b2b_div1", lat, 33, 32'hFFFF_FFFF, 16'h0000, 1'b0);
    tick();

    run_op(32'd5, 16'd9, lat);
    expect_res("small", lat, 33, 32'd0, 16'd5, 1'b0);
    tick();
    run_op(32'd0, 16'd3, lat);
    expect_res("zero_dd", lat, 33, 32'd0, 16'd0, 1'b0);
    tick();

    run_op(32'h1234_ABCD, 16'd0, lat);
    expect_res("dbz", lat, 1, 32'hFFFF_FFFF, 16'hABCD, 1'b1);
    tick();
    chk("dbz.valid_drop", 32'(bus.valid),       32'd0);
    chk("dbz.hold",       32'(bus.div_by_zero), 32'd1);
    run_op(32'd100, 16'd10, lat);
    expect_res("dbz_clear", lat, 33, 32'd10, 16'd0, 1'b0);
    tick();

    bus.start    = 1'b1;
    bus.dividend = 32'd50000;
    bus.divisor  = 16'd300;
    tick();
    bus.start = 1'b0;
    lat = 1;
    repeat (9) begin
      tick();
      lat++;
    end
    chk("ign.busy",  32'(bus.busy),  32'd1);
    chk("ign.ready", 32'(bus.ready), 32'd0);
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 16'd2;
    tick();
    lat++;
    bus.start = 1'b0;
    wait_valid(lat);
    expect_res("ignore", lat, 33, 32'd166, 16'd200, 1'b0);

    run_op(32'd65535, 16'd256, lat);
    expect_res("b2b", lat, 33, 32'd255, 16'd255, 1'b0);
    run_op(32'hABCD_0042, 16'd0, lat);
    expect_res("b2b_dbz", lat, 1, 32'hFFFF_FFFF, 16'h0042, 1'b1);
    tick();

    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd7;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid.ready", 32'(bus.ready),       32'd1);
    chk("rst_mid.busy",  32'(bus.busy),        32'd0);
    chk("rst_mid.valid", 32'(bus.valid),       32'd0);
    chk("rst_mid.quot",  bus.quotient,         32'd0);
    chk("rst_mid.rem",   32'(bus.remainder),   32'd0);
    chk("rst_mid.dbz",   32'(bus.div_by_zero), 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.valid === 1'b1) seen = 1;
    end
    chk("rst_mid.no_valid", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      dd = $urandom;
      dv = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      run_op(dd, dv, lat);
      expect_res("rand", lat, 33, dd / 32'(dv), 16'(dd % 32'(dv)), 1'b0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
